gsim_sweep_ctrl: RTL and testbench

- Sequencer for the Gauss-Seidel iteration datapath: the single shared row-update unit plus the 16-entry x register file and the b register file.
- Accepts the 16-sample b stream and writes it into b storage.
- Issues row updates 0..N-1 one at a time; a row is issued only after the previous write-back, which preserves Gauss-Seidel ordering.
- Tracks per-sweep convergence, stops on tolerance or iteration cap, then streams the solution vector out.

---
 rtl/gsim_pkg.sv | 21 ++
 rtl/gsim_sweep_ctrl.sv | 149 ++++++++++++++
 tb/tb_gsim_sweep_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsim_pkg.sv
// Shared definitions for the Gauss-Seidel sweep sequencer: default sizes,
// settle threshold and the controller state encoding.
package gsim_pkg;

    localparam int N_DEF      = 16;
    localparam int IDX_W_DEF  = 4;
    localparam int DW_DEF     = 32;
    localparam int ITER_W_DEF = 10;

    localparam logic [31:0] TOL_DEF = 32'h0000_0100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_SWEEP_END,
        S_OUT
    } state_t;

endpackage

// File: rtl/gsim_sweep_ctrl.sv
// Gauss-Seidel sequencer: loads b, issues one row update at a time through the
// shared datapath, tracks convergence per sweep and streams x out in order.
module gsim_sweep_ctrl
    import gsim_pkg::*;
#(
    parameter int              N        = N_DEF,
    parameter int              IDX_W    = IDX_W_DEF,
    parameter int              DW       = DW_DEF,
    parameter int              ITER_W   = ITER_W_DEF,
    parameter int              MAX_ITER = 512,
    parameter int              MIN_ITER = 1,
    parameter logic [DW-1:0]   TOL      = DW'(TOL_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    input  logic [15:0]       b_in,
    output logic              b_wr_en,
    output logic [IDX_W-1:0]  b_wr_addr,
    output logic [15:0]       b_wr_data,
    output logic              x_clr,
    output logic              dp_start,
    output logic [IDX_W-1:0]  dp_row,
    input  logic              dp_done,
    input  logic [DW-1:0]     dp_delta,
    output logic              x_wr_en,
    output logic [IDX_W-1:0]  x_rd_addr,
    input  logic [DW-1:0]     x_rd_data,
    output logic              out_valid,
    output logic [DW-1:0]     x_out,
    output logic              busy,
    output logic              converged,
    output logic [ITER_W-1:0] iter_count
);

    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N - 1);
    localparam logic [ITER_W-1:0] MAX_I = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] MIN_I = ITER_W'(MIN_ITER);

    state_t              r_state;
    logic [IDX_W-1:0]    r_load_cnt;
    logic [IDX_W-1:0]    r_row;
    logic [IDX_W-1:0]    r_out_k;
    logic                r_dirty;
    logic                r_conv;
    logic [ITER_W-1:0]   r_iter;
    logic                r_out_valid;
    logic [DW-1:0]       r_x_out;

    logic                w_load_ok;
    logic [ITER_W-1:0]   w_iter_nxt;

    // Samples are accepted only while idle or loading; reset masks a held in_en.
    assign w_load_ok  = reset && in_en && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_iter_nxt = r_iter + ITER_W'(1);

    assign b_wr_en    = w_load_ok;
    assign b_wr_addr  = (w_load_ok && r_state == S_LOAD) ? r_load_cnt : '0;
    assign b_wr_data  = w_load_ok ? b_in : '0;
    assign x_clr      = w_load_ok && (r_state == S_IDLE);
    assign dp_start   = (r_state == S_ISSUE);
    assign dp_row     = r_row;
    assign x_wr_en    = (r_state == S_WAIT) && dp_done;
    assign x_rd_addr  = r_out_k;
    assign out_valid  = r_out_valid;
    assign x_out      = r_x_out;
    assign busy       = (r_state != S_IDLE);
    assign converged  = r_conv;
    assign iter_count = r_iter;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_load_cnt  <= '0;
            r_row       <= '0;
            r_out_k     <= '0;
            r_dirty     <= 1'b0;
            r_conv      <= 1'b0;
            r_iter      <= '0;
            r_out_valid <= 1'b0;
            r_x_out     <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_en) begin
                        r_conv     <= 1'b0;
                        r_iter     <= '0;
                        r_load_cnt <= IDX_W'(1);
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_en) begin
                        r_load_cnt <= r_load_cnt + IDX_W'(1);
                        if (r_load_cnt == LAST) begin
                            r_row   <= '0;
                            r_dirty <= 1'b0;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Next row is issued only after this write-back, keeping GS order.
                    if (dp_done) begin
                        r_dirty <= r_dirty | (dp_delta > TOL);
                        if (r_row == LAST) begin
                            r_state <= S_SWEEP_END;
                        end else begin
                            r_row   <= r_row + IDX_W'(1);
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_SWEEP_END: begin
                    r_iter <= w_iter_nxt;
                    if (w_iter_nxt >= MIN_I && !r_dirty) begin
                        r_conv  <= 1'b1;
                        r_out_k <= '0;
                        r_state <= S_OUT;
                    end else if (w_iter_nxt == MAX_I) begin
                        r_conv  <= 1'b0;
                        r_out_k <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_dirty <= 1'b0;
                        r_row   <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_OUT: begin
                    r_out_valid <= 1'b1;
                    r_x_out     <= x_rd_data;
                    if (r_out_k == LAST) begin
                        r_out_k <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_out_k <= r_out_k + IDX_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_sweep_ctrl.sv
// Bench for gsim_sweep_ctrl: a behavioural datapath/x-file model drives the DUT,
// a per-cycle monitor checks every strobe against expected queues.
module tb_gsim_sweep_ctrl;

    localparam int          N        = 16;
    localparam int          IDX_W    = 4;
    localparam int          DW       = 32;
    localparam int          ITER_W   = 10;
    localparam int          MAX_ITER = 8;
    localparam int          MIN_ITER = 1;
    localparam logic [31:0] TOL      = 32'h0000_0100;

    // clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              in_en = 1'b0;
    logic [15:0]       b_in = '0;
    logic              b_wr_en;
    logic [IDX_W-1:0]  b_wr_addr;
    logic [15:0]       b_wr_data;
    logic              x_clr;
    logic              dp_start;
    logic [IDX_W-1:0]  dp_row;
    logic              dp_done = 1'b0;
    logic [DW-1:0]     dp_delta = '0;
    logic              x_wr_en;
    logic [IDX_W-1:0]  x_rd_addr;
    logic [DW-1:0]     x_rd_data;
    logic              out_valid;
    logic [DW-1:0]     x_out;
    logic              busy;
    logic              converged;
    logic [ITER_W-1:0] iter_count;

    gsim_sweep_ctrl #(
        .N(N), .IDX_W(IDX_W), .DW(DW), .ITER_W(ITER_W),
        .MAX_ITER(MAX_ITER), .MIN_ITER(MIN_ITER), .TOL(TOL)
    ) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .x_clr(x_clr), .dp_start(dp_start), .dp_row(dp_row),
        .dp_done(dp_done), .dp_delta(dp_delta), .x_wr_en(x_wr_en),
        .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
        .out_valid(out_valid), .x_out(x_out), .busy(busy),
        .converged(converged), .iter_count(iter_count)
    );

    // bookkeeping
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // behavioural model state
    int          policy  = 0;
    int          k_sw    = 0;
    int          bad_row = 0;
    int          lat     = 2;
    int          run_id  = 0;
    bit          inj     = 1'b0;
    logic [15:0] b_arr[N];
    logic [31:0] dp_val = '0;
    logic [31:0] x_mem[N];

    logic [19:0] exp_b_q[$];
    logic [31:0] exp_out_q[$];

    function automatic logic [31:0] delta_of(input int s, input int r);
        case (policy)
            0:       return 32'h0;
            1:       return (r == 9 && s <= 3) ? TOL + 32'd1 : 32'h0;
            2:       return 32'hFFFF_FFFF;
            default: return (s <= k_sw && r == bad_row) ? TOL + 32'(1 + s)
                          : ((r % 3 == 0) ? TOL : 32'(r));
        endcase
    endfunction

    // Sweeps until one is clean (after MIN_ITER) or the cap is reached.
    task automatic model_iter(output int it, output bit conv);
        bit clean;
        it   = MAX_ITER;
        conv = 1'b0;
        for (int s = 1; s <= MAX_ITER; s++) begin
            clean = 1'b1;
            for (int r = 0; r < N; r++)
                if (delta_of(s, r) > TOL) clean = 1'b0;
            if (s >= MIN_ITER && clean) begin
                it   = s;
                conv = 1'b1;
                return;
            end
        end
    endtask

    // x register file: written by the DUT's strobe, read combinationally.
    always @(posedge clk) begin
        if (x_clr) begin
            for (int i = 0; i < N; i++) x_mem[i] <= '0;
        end else if (x_wr_en) begin
            x_mem[dp_row] <= dp_val;
        end
    end
    assign x_rd_data = x_mem[x_rd_addr];

    // row-update datapath: answers dp_start after lat cycles, optional junk dp_done
    initial begin : datapath
        int pend;
        int cnt;
        int n;
        int seen;
        int row;
        pend = 0; cnt = 0; n = 0; seen = -1; row = 0;
        forever begin
            @(posedge clk); #1;
            if (run_id != seen) begin
                seen = run_id;
                n    = 0;
            end
            dp_done  = 1'b0;
            dp_delta = '0;
            if (!reset) begin
                pend = 0;
            end else if (dp_start) begin
                pend = 1;
                cnt  = lat;
                row  = int'(dp_row);
                if (inj && $urandom_range(0, 1) == 1) begin
                    dp_done  = 1'b1;
                    dp_delta = 32'hFFFF_FFFF;
                end
            end else if (pend != 0) begin
                cnt--;
                if (cnt == 0) begin
                    pend     = 0;
                    dp_done  = 1'b1;
                    dp_delta = delta_of(n / N + 1, row);
                    dp_val   = {16'(n / N + 1), b_arr[row]};
                    n++;
                end
            end else if (inj && $urandom_range(0, 3) == 0) begin
                dp_done  = 1'b1;
                dp_delta = 32'hFFFF_FFFF;
            end
        end
    end

    // scoreboard monitor, sampled on the falling edge
    int cyc = 0;
    int start_cnt = 0;
    int xwr_cnt = 0;
    int out_cnt = 0;
    int bwr_cnt = 0;
    int xclr_cnt = 0;
    int last_wr_cyc = 0;
    bit prev_ov = 1'b0;

    initial begin : monitor
        logic [19:0] eb;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (x_clr) begin
                    start_cnt = 0; xwr_cnt = 0; out_cnt = 0; bwr_cnt = 0; xclr_cnt = 0;
                    last_wr_cyc = -100;
                end
                if (x_clr) xclr_cnt++;
                if (b_wr_en) begin
                    bwr_cnt++;
                    if (exp_b_q.size() == 0) begin
                        chk("b_wr_unexpected", {b_wr_addr, b_wr_data}, 64'h0);
                    end else begin
                        eb = exp_b_q.pop_front();
                        chk("b_wr", {b_wr_addr, b_wr_data}, eb);
                    end
                    if (int'(b_wr_addr) == N - 1) last_wr_cyc = cyc;
                end
                if (dp_start) begin
                    if (start_cnt == 0) chk("issue_after_load", 64'(cyc - last_wr_cyc), 64'd1);
                    chk("dp_row_start", dp_row, 64'(start_cnt % N));
                    start_cnt++;
                end
                if (x_wr_en) begin
                    chk("x_wr_row", dp_row, 64'(xwr_cnt % N));
                    xwr_cnt++;
                end
                if (out_valid) begin
                    if (out_cnt > 0) chk("out_contig", prev_ov, 64'd1);
                    if (exp_out_q.size() == 0) chk("out_unexpected", x_out, 64'h0);
                    else chk("x_out", x_out, exp_out_q.pop_front());
                    out_cnt++;
                end
                prev_ov = out_valid;
            end
        end
    end

    // driver tasks
    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_strobes"}, {b_wr_en, x_clr, dp_start, x_wr_en, out_valid, busy, converged}, 64'h0);
        chk({tag, "_b_wr"}, {b_wr_addr, b_wr_data}, 64'h0);
        chk({tag, "_addr"}, {dp_row, x_rd_addr}, 64'h0);
        chk({tag, "_x_out"}, x_out, 64'h0);
        chk({tag, "_iter"}, iter_count, 64'h0);
    endtask

    task automatic load_b(input int gap, input bit seq);
        int g;
        logic [15:0] v;
        for (int i = 0; i < N; i++) begin
            v = seq ? 16'(i + 1) : 16'($urandom);
            b_arr[i] = v;
            exp_b_q.push_back({4'(i), v});
            g = (gap < 0) ? $urandom_range(0, 3) : gap;
            repeat (g) begin
                in_en = 1'b0;
                b_in  = 16'($urandom);
                @(posedge clk); #1;
            end
            in_en = 1'b1;
            b_in  = v;
            @(posedge clk); #1;
        end
        in_en = 1'b0;
    endtask

    task automatic run(input int l, input int pol, input int gap, input bit seq,
                       input bit do_inj, input int lit_iter, input int lit_conv);
        int it;
        bit cv;
        int cy;
        run_id++;
        lat    = l;
        policy = pol;
        if (pol == 3) begin
            k_sw    = $urandom_range(0, 9);
            bad_row = $urandom_range(0, N - 1);
        end
        model_iter(it, cv);
        if (lit_iter >= 0) begin
            chk("model_iter_lit", 64'(it), 64'(lit_iter));
            chk("model_conv_lit", 64'(cv), 64'(lit_conv));
        end
        load_b(gap, seq);
        for (int k = 0; k < N; k++) exp_out_q.push_back({16'(it), b_arr[k]});
        inj = do_inj;
        cy  = 0;
        while (out_cnt < N && cy < 5000) begin
            if (inj && busy) begin
                in_en = 1'($urandom_range(0, 1));
                b_in  = 16'($urandom);
            end else begin
                in_en = 1'b0;
            end
            @(posedge clk); #1;
            cy++;
        end
        in_en = 1'b0;
        inj   = 1'b0;
        if (cy >= 5000) chk("run_timeout", 64'(out_cnt), 64'(N));
        repeat (2) @(posedge clk);
        #1;
        chk("iter_count", iter_count, 64'(it));
        chk("converged", converged, 64'(cv));
        chk("dp_start_count", 64'(start_cnt), 64'(it * N));
        chk("x_wr_count", 64'(xwr_cnt), 64'(it * N));
        chk("b_wr_count", 64'(bwr_cnt), 64'(N));
        chk("x_clr_count", 64'(xclr_cnt), 64'd1);
        chk("out_count", 64'(out_cnt), 64'(N));
        chk("queues_empty", 64'(exp_b_q.size() + exp_out_q.size()), 64'd0);
        chk("idle_after", {busy, out_valid}, 64'h0);
        if (lit_iter >= 0) chk("iter_lit", iter_count, 64'(lit_iter));
        exp_b_q.delete();
        exp_out_q.delete();
    endtask

    initial begin : main
        int cy;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 64'd0);

        run(2, 0, 0, 1'b1, 1'b0, 1, 1);
        run(1, 0, 2, 1'b0, 1'b0, 1, 1);
        run(3, 1, 0, 1'b0, 1'b0, 4, 1);
        run(2, 2, 0, 1'b0, 1'b0, 8, 0);

        // reset in WAIT of row 7, sweep 2
        run_id++;
        lat    = 2;
        policy = 2;
        load_b(0, 1'b0);
        cy = 0;
        while (start_cnt < N + 8 && cy < 2000) begin
            @(posedge clk); #1;
            cy++;
        end
        if (cy >= 2000) chk("reset_wait_timeout", 64'(start_cnt), 64'(N + 8));
        #1;
        reset = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_b_q.delete();
        exp_out_q.delete();
        @(posedge clk); #1;
        run(2, 1, -1, 1'b0, 1'b0, 4, 1);

        run(2, 1, 0, 1'b0, 1'b1, 4, 1);
        repeat (4) run($urandom_range(1, 4), 3, -1, 1'b0, 1'($urandom_range(0, 1)), -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
